axi4l_read_master: RTL and testbench

AXI4L_READ_MASTER -- requirements
Module: axi4l_read_master

---
 rtl/axi4l_pkg.sv | 13 +
 rtl/axi4l_stream_reg.sv | 30 +++
 rtl/axi4l_read_master.sv | 136 +++++++++++++
 tb/tb_axi4l_read_master.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - shared FSM state and AXI response encodings
package axi4l_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi4l_stream_reg.sv
// rtl/axi4l_stream_reg.sv - 1-deep valid/ready output register
module axi4l_stream_reg #(
   parameter int W = 10
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         s_tvalid,
   output logic         s_tready,
   input  logic [W-1:0] s_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic [W-1:0] m_tdata
);

   // A load may coincide with the consumer draining the current word.
   assign s_tready = ~m_tvalid | m_tready;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
      end else if (s_tvalid) begin
         m_tvalid <= 1'b1;
         m_tdata  <= s_tdata;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axi4l_read_master.sv
// rtl/axi4l_read_master.sv - AXI4-lite burst read master with bounded outstanding reads
module axi4l_read_master
   import axi4l_pkg::*;
#(
   parameter int MAX_OR     = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  count,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [1:0]            arprot,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_resp
);

   localparam int OW = $clog2(MAX_OR + 1);
   localparam logic [OW-1:0]        MAX_OUT = OW'(MAX_OR);
   localparam logic [CNT_WIDTH-1:0] ERR_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  issued;
   logic [CNT_WIDTH-1:0]  received;
   logic [OW-1:0]         outstanding;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  s_ready;
   logic                  finish;
   logic                  idle_start;

   assign ar_hs      = arvalid & arready;
   assign r_hs       = rvalid & rready;
   assign rready     = (outstanding != '0) & s_ready;
   assign araddr     = base_q + ADDR_WIDTH'(issued);
   assign arprot     = 2'b00;
   assign busy       = (state != IDLE);
   assign idle_start = (state == IDLE) & start;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_nxt;
   end

   // arvalid is a pure function of registered counters, so it cannot drop mid-stall.
   always_comb begin
      state_nxt = state;
      arvalid   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start && count != '0) state_nxt = ISSUE;
         end
         ISSUE: begin
            arvalid = (issued < cnt_q) && (outstanding < MAX_OUT);
            if (ar_hs && (issued + ONE) == cnt_q) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (received == cnt_q && !out_valid) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         done     <= 1'b0;
         err_cnt  <= '0;
         base_q   <= '0;
         cnt_q    <= '0;
         issued   <= '0;
         received <= '0;
      end else begin
         done <= finish | (idle_start & (count == '0));
         if (idle_start) begin
            err_cnt <= '0;
            if (count != '0) begin
               base_q   <= base_addr;
               cnt_q    <= count;
               issued   <= '0;
               received <= '0;
            end
         end else begin
            if (ar_hs) issued <= issued + ONE;
            if (r_hs) begin
               received <= received + ONE;
               if (rresp != OKAY && err_cnt != ERR_MAX) err_cnt <= err_cnt + ONE;
            end
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         outstanding <= '0;
      end else begin
         case ({ar_hs, r_hs})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   axi4l_stream_reg #(.W(DATA_WIDTH + 2)) u_out_reg (
      .aclk     (aclk),
      .areset   (areset),
      .s_tvalid (r_hs),
      .s_tready (s_ready),
      .s_tdata  ({rresp, rdata}),
      .m_tvalid (out_valid),
      .m_tready (out_ready),
      .m_tdata  ({out_resp, out_data})
   );

endmodule

// File: tb/tb_axi4l_read_master.sv
// tb/tb_axi4l_read_master.sv - table-driven bench for axi4l_read_master
module tb_axi4l_read_master;
   import axi4l_pkg::*;

   logic       aclk;
   logic       areset;
   logic       start;
   logic [2:0] base_addr;
   logic [7:0] count;
   logic       busy;
   logic       done;
   logic [7:0] err_cnt;
   logic       arvalid;
   logic       arready;
   logic [2:0] araddr;
   logic [1:0] arprot;
   logic       rvalid;
   logic       rready;
   logic [7:0] rdata;
   logic [1:0] rresp;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_resp;

   axi4l_read_master dut (
      .aclk      (aclk),
      .areset    (areset),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .err_cnt   (err_cnt),
      .arvalid   (arvalid),
      .arready   (arready),
      .araddr    (araddr),
      .arprot    (arprot),
      .rvalid    (rvalid),
      .rready    (rready),
      .rdata     (rdata),
      .rresp     (rresp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_resp  (out_resp)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic [2:0]  base;
      logic [7:0]  cnt;
      logic [15:0] emask;
      int          ar_mode;
      int          out_mode;
      int          rhold;
      int          hold_ar;
      int          exp_ar;
      int          done_cyc;
      logic [7:0]  exp_err;
      logic [2:0]  exp_last;
   } vec_t;

   vec_t       vecs [9];
   int         checks;
   int         failures;
   int         n_ar, n_r, n_out, n_done, first_done, outst;
   logic [2:0] last_addr;
   logic [2:0] addr_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Slave model: replies in order with rdata = A0 + address, errors per emask bit.
   task automatic run_burst(input int v, input int abort_r);
      bit         fin;
      bit         prev_stall;
      logic [2:0] prev_addr;
      logic [2:0] ea;
      fin = 1'b0; prev_stall = 1'b0; prev_addr = '0;
      n_ar = 0; n_r = 0; n_out = 0; n_done = 0; first_done = -1; outst = 0;
      last_addr = '0;
      addr_q.delete();
      start = 1'b1; base_addr = vecs[v].base; count = vecs[v].cnt;
      @(negedge aclk);
      start = 1'b0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         arready   = (vecs[v].ar_mode == 0) ? 1'b1 : (cyc % 3 == 2);
         out_ready = (vecs[v].out_mode == 0) ? 1'b1 : !(cyc >= 4 && cyc < 14);
         if (addr_q.size() > 0 && cyc >= vecs[v].rhold) begin
            rvalid = 1'b1;
            rdata  = 8'hA0 + {5'b0, addr_q[0]};
            rresp  = vecs[v].emask[n_r] ? SLVERR : OKAY;
         end else begin
            rvalid = 1'b0; rdata = '0; rresp = OKAY;
         end
         #1;
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = cyc;
         end
         if (vecs[v].hold_ar > 0 && cyc == vecs[v].rhold - 1) begin
            chk("hold_ar_count", 32'(n_ar), 32'(vecs[v].hold_ar));
            chk("hold_arvalid", 32'(arvalid), 32'd0);
         end
         if (prev_stall) begin
            chk("ar_stall_valid", 32'(arvalid), 32'd1);
            chk("ar_stall_addr", 32'(araddr), 32'(prev_addr));
         end
         if (outst >= 8) chk("ar_limit", 32'(arvalid), 32'd0);
         if (out_valid && !out_ready) chk("rready_bp", 32'(rready), 32'd0);
         if (arvalid && arready) begin
            ea = vecs[v].base + 3'(n_ar);
            chk("araddr", 32'(araddr), 32'(ea));
            addr_q.push_back(araddr);
            last_addr = araddr;
            n_ar++; outst++;
         end
         if (rvalid && rready) begin
            void'(addr_q.pop_front());
            n_r++; outst--;
         end
         if (out_valid && out_ready) begin
            ea = vecs[v].base + 3'(n_out);
            chk("out_data", 32'(out_data), 32'(8'hA0 + {5'b0, ea}));
            chk("out_resp", 32'(out_resp), 32'(vecs[v].emask[n_out] ? SLVERR : OKAY));
            n_out++;
         end
         prev_stall = arvalid && !arready;
         prev_addr  = araddr;
         if (first_done >= 0 && cyc == first_done + 2) fin = 1'b1;
         if (abort_r > 0 && n_r == abort_r) fin = 1'b1;
         if (!fin) @(negedge aclk);
      end
      chk("burst_end", 32'(fin), 32'd1);
   endtask

   task automatic check_result(input int v);
      chk("ar_count", 32'(n_ar), 32'(vecs[v].exp_ar));
      chk("out_count", 32'(n_out), 32'(vecs[v].exp_ar));
      chk("done_count", 32'(n_done), 32'd1);
      chk("err_cnt", 32'(err_cnt), 32'(vecs[v].exp_err));
      chk("busy_after", 32'(busy), 32'd0);
      if (vecs[v].exp_ar > 0) chk("last_araddr", 32'(last_addr), 32'(vecs[v].exp_last));
      if (vecs[v].done_cyc >= 0) chk("done_latency", 32'(first_done), 32'(vecs[v].done_cyc));
   endtask

   initial begin
      checks = 0; failures = 0;
      vecs[0] = '{3'd3, 8'd4,  16'h0000, 0, 0, 0,  0, 4,  -1, 8'd0, 3'd6};
      vecs[1] = '{3'd6, 8'd4,  16'h0000, 0, 0, 0,  0, 4,  -1, 8'd0, 3'd1};
      vecs[2] = '{3'd0, 8'd6,  16'h0012, 0, 0, 0,  0, 6,  -1, 8'd2, 3'd5};
      vecs[3] = '{3'd5, 8'd12, 16'h0000, 0, 0, 20, 8, 12, -1, 8'd0, 3'd0};
      vecs[4] = '{3'd2, 8'd8,  16'h0000, 1, 1, 0,  0, 8,  -1, 8'd0, 3'd1};
      vecs[5] = '{3'd1, 8'd3,  16'h0007, 1, 0, 0,  0, 3,  -1, 8'd3, 3'd3};
      vecs[6] = '{3'd0, 8'd0,  16'h0000, 0, 0, 0,  0, 0,  0,  8'd0, 3'd0};
      vecs[7] = '{3'd0, 8'd8,  16'h0001, 0, 0, 0,  0, 8,  -1, 8'd1, 3'd7};
      vecs[8] = '{3'd4, 8'd2,  16'h0000, 0, 0, 0,  0, 2,  -1, 8'd0, 3'd5};

      areset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = OKAY; out_ready = 1'b1;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_regs", 32'({araddr, out_data, out_resp, err_cnt}), 32'd0);
      chk("arprot", 32'(arprot), 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);

      for (int v = 0; v < 7; v++) begin
         run_burst(v, 0);
         check_result(v);
      end

      // Reset after three responses of an eight-read burst, then a clean two-read burst.
      run_burst(7, 3);
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_err_seen", 32'(err_cnt), 32'd1);
      areset = 1'b1; rvalid = 1'b0; arready = 1'b0;
      #2;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
      chk("mid_rst_rready", 32'(rready), 32'd0);
      chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      run_burst(8, 0);
      check_result(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
